// File: rtl/rf_wport_sched_pkg.sv
// rtl/rf_wport_sched_pkg.sv - shared pipeline types for the regfile write-port scheduler
package rf_wport_sched_pkg;

  typedef logic [4:0]  creg_addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_FORCE
  } rf_sched_state_t;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-destination vector for in-flight mul/div results
module rf_scoreboard
  import rf_wport_sched_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_set_en,
  input  creg_addr_t i_set_wa,
  input  logic       i_clr_en,
  input  creg_addr_t i_clr_wa,
  input  creg_addr_t i_ra1,
  input  creg_addr_t i_ra2,
  output logic       o_busy1,
  output logic       o_busy2
);

  logic [31:0] r_pend;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  assign w_set_mask = (i_set_en && (i_set_wa != '0)) ? (32'd1 << i_set_wa) : 32'd0;
  assign w_clr_mask = i_clr_en ? (32'd1 << i_clr_wa) : 32'd0;

  // Applying the set after the clear lets a fresh issue survive a retiring write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_busy1 = (i_ra1 != '0) && r_pend[i_ra1];
  assign o_busy2 = (i_ra2 != '0) && r_pend[i_ra2];

endmodule

// File: rtl/rf_wport_sched.sv
// rtl/rf_wport_sched.sv - arbitrates the single regfile write port between pipeline and mul/div
module rf_wport_sched
  import rf_wport_sched_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       p_valid,
  input  creg_addr_t p_wa,
  input  word_t      p_wd,
  input  logic       m_valid,
  input  creg_addr_t m_wa,
  input  word_t      m_wd,
  output logic       m_ready,
  input  logic       m_issue,
  input  creg_addr_t m_issue_wa,
  input  creg_addr_t ra1,
  input  creg_addr_t ra2,
  output logic       busy1,
  output logic       busy2,
  output logic       stall_req,
  output logic       we,
  output creg_addr_t wa,
  output word_t      wd
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  rf_sched_state_t r_state;
  logic [CW-1:0]   r_wait;
  creg_addr_t      r_buf_wa;
  word_t           r_buf_wd;

  logic            w_m_xfer;
  logic            w_sel_valid;
  logic            w_sel_m;
  creg_addr_t      w_sel_wa;
  word_t           w_sel_wd;
  logic            w_drain;
  logic            w_cap;
  logic [CW-1:0]   w_wait_nxt;

  assign w_drain    = (r_state == S_FORCE) || ((r_state == S_HOLD) && !p_valid);
  assign m_ready    = (r_state == S_IDLE) || w_drain;
  assign stall_req  = (r_state == S_FORCE);
  assign w_m_xfer   = m_valid && m_ready;
  assign w_wait_nxt = r_wait + CW'(1);

  // Pipeline wins unless the buffer is being drained; m is captured whenever it loses.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_m     = 1'b0;
    w_sel_wa    = '0;
    w_sel_wd    = '0;
    w_cap       = 1'b0;
    if (w_drain) begin
      w_sel_valid = 1'b1;
      w_sel_m     = 1'b1;
      w_sel_wa    = r_buf_wa;
      w_sel_wd    = r_buf_wd;
      w_cap       = w_m_xfer;
    end else if (p_valid) begin
      w_sel_valid = 1'b1;
      w_sel_wa    = p_wa;
      w_sel_wd    = p_wd;
      w_cap       = w_m_xfer;
    end else if (w_m_xfer) begin
      w_sel_valid = 1'b1;
      w_sel_m     = 1'b1;
      w_sel_wa    = m_wa;
      w_sel_wd    = m_wd;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_wait   <= '0;
      r_buf_wa <= '0;
      r_buf_wd <= '0;
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
    end else begin
      we <= w_sel_valid && (w_sel_wa != '0);
      if (w_sel_valid) begin
        wa <= w_sel_wa;
        wd <= w_sel_wd;
      end
      if (w_cap) begin
        r_buf_wa <= m_wa;
        r_buf_wd <= m_wd;
        r_wait   <= '0;
        r_state  <= S_HOLD;
      end else if (w_drain) begin
        r_state <= S_IDLE;
      end else if (r_state == S_HOLD) begin
        r_wait <= w_wait_nxt;
        if (w_wait_nxt >= CW'(STARVE_MAX)) r_state <= S_FORCE;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .resetn   (resetn),
    .i_set_en (m_issue),
    .i_set_wa (m_issue_wa),
    .i_clr_en (w_sel_valid && w_sel_m),
    .i_clr_wa (w_sel_wa),
    .i_ra1    (ra1),
    .i_ra2    (ra2),
    .o_busy1  (busy1),
    .o_busy2  (busy2)
  );

endmodule

// File: doc/rf_wport_sched.md
RF_WPORT_SCHED -- requirements
Module: rf_wport_sched

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of cycles a buffered mul/div result waits before it forces the write port.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have ports p_valid/p_wa/p_wd, input, 1/5/32, the pipeline writeback request; it has no ready and is never dropped.
REQ-005 SHALL have ports m_valid/m_wa/m_wd, input, 1/5/32, the mul/div result; m_ready, output, 1; transfer occurs when m_valid && m_ready.
REQ-006 SHALL have ports m_issue/m_issue_wa, input, 1/5, marking a destination as pending when a mul/div op issues.
REQ-007 SHALL have ports ra1/ra2, input, 5, and busy1/busy2, output, 1, the hazard query for the two read addresses.
REQ-008 SHALL have port stall_req, output, 1, requesting a one-cycle pipeline writeback stall.
REQ-009 SHALL have ports we/wa/wd, output, 1/5/32, the registered regfile write port.

Function
REQ-010 SHALL hold a one-entry mul/div buffer (valid, addr, data) and m_ready = !buffer_valid || buffer drained this cycle.
REQ-011 SHALL implement states IDLE (buffer empty), HOLD (buffer full, waiting) and FORCE (buffer full, stall_req=1).
REQ-012 SHALL, in IDLE: m transfer with p_valid=0 -> write m directly next cycle, stay IDLE; m transfer with p_valid=1 -> capture into buffer, go HOLD, wait count=0.
REQ-013 SHALL, in HOLD: p_valid=0 -> write buffer, go IDLE (or refill on a simultaneous m transfer); p_valid=1 -> write p, increment wait count; count reaching STARVE_MAX -> go FORCE.
REQ-014 SHALL, in FORCE: drive stall_req=1 combinationally; write buffer regardless of p_valid; go IDLE next cycle; the pipeline guarantees p_valid=0 while stall_req=1, and a p_valid in FORCE SHALL be ignored.
REQ-015 SHALL give pipeline priority over the buffer in all states except FORCE.
REQ-016 SHALL register we/wa/wd: the winner in cycle N appears on outputs in cycle N+1; we=0 when no winner.
REQ-017 SHALL suppress writes to address 0 (we=0) while still completing the handshake.
REQ-018 SHALL keep a 32-bit pending vector: set bit m_issue_wa on m_issue (not for address 0); clear the bit when that mul/div write reaches we; when set and clear coincide on the same bit, set wins.
REQ-019 SHALL drive busy1 = pending[ra1], busy2 = pending[ra2] combinationally; address 0 is never busy.
REQ-020 SHALL, when p and m target the same address in one cycle, commit p first and m later (m value is final).

Reset
REQ-021 SHALL, while resetn=0, force state IDLE, buffer invalid, wait count 0, pending 0, we=0, wa=0, wd=0, m_ready=1, stall_req=0.
REQ-022 SHALL discard any buffered result and pending bits on reset assertion mid-operation, with no write emitted after release until a new request.

Structure
REQ-023 SHALL take creg_addr_t and word_t from the shared pipeline package; the state enum rf_sched_state_t and STARVE_MAX default belong there too.
REQ-024 SHALL place the pending vector in one sub-module rf_scoreboard (set/clear/query); everything else stays flat.

Verification
REQ-025 p_valid=1 wa=3 wd=0x11 alone -> next cycle we=1 wa=3 wd=0x11, m_ready stays 1.
REQ-026 m_valid=1 wa=5 wd=0x22 with p_valid=1 wa=6 -> cycle+1 writes 6, state HOLD, m_ready=0; p_valid drops -> next write 5/0x22, IDLE.
REQ-027 buffer full, p_valid held 1 for 4 cycles -> FORCE with stall_req=1 for exactly one cycle, buffered write follows, then IDLE.
REQ-028 m_issue wa=7, then ra1=7 -> busy1=1 until mul/div write to 7 appears on we, then busy1=0; ra2=0 -> busy2=0 throughout.
REQ-029 m_valid wa=0 wd=0xFF -> handshake completes, we stays 0.
REQ-030 resetn pulled low while in HOLD -> all outputs at reset values immediately; after release no write of the discarded result.
